switch_debounce_multi: RTL and testbench
========================================

# switch_debounce_multi

Parametrised multi-channel switch conditioner for the Go Board top level. It takes NUM_CH raw, asynchronous, bouncing push-button inputs and synchronises each one into `i_Clk`. Each channel is debounced independently with its own stability counter. Per channel it produces a clean level, single-cycle rise and fall pulses, and a toggle (latch-on-press) state. It generalises the single-switch toggle path to N channels, a configurable debounce window and a selectable output mode.

## Interface

Parameters:
- `NUM_CH`, default 4: number of switch channels, 1..8.
- `DEBOUNCE_CYCLES`, default 250000: cycles a new value must persist before it is accepted. The default is 10 ms at 25 MHz. Minimum value is 2.
- `TOGGLE_MODE`, default 0: selects what drives `o_Out`.
  - 0: `o_Out` = debounced level.
  - 1: `o_Out` = toggle state.

Ports (one clock; reset is synchronous and active-low):
- `i_Clk`, input, 1 bit: system clock; all logic on its rising edge.
- `i_Rst_L`, input, 1 bit: synchronous active-low reset.
- `i_Switch`, input, NUM_CH bits: raw switch inputs, asynchronous.
- `i_Toggle_Clr`, input, NUM_CH bits: per-channel synchronous clear of the toggle state.
- `o_Level`, output, NUM_CH bits: debounced, synchronised level.
- `o_Rise`, output, NUM_CH bits: 1-cycle pulse when `o_Level` goes 0→1.
- `o_Fall`, output, NUM_CH bits: 1-cycle pulse when `o_Level` goes 1→0.
- `o_Toggle`, output, NUM_CH bits: toggle state; flips on every accepted rise.
- `o_Out`, output, NUM_CH bits: mode-selected output, either `o_Level` or `o_Toggle` per `TOGGLE_MODE`.

## Operation

Per-channel datapath: 2-flop synchroniser (`sync1`, `sync2`) → debounce counter → stable register.

Counter:
- Width is $clog2(DEBOUNCE_CYCLES); it counts 0..DEBOUNCE_CYCLES-1.
- If `sync2` equals stable: counter is cleared to 0.
- If `sync2` differs from stable and counter is below DEBOUNCE_CYCLES-1: counter increments.
- If `sync2` differs from stable and counter equals DEBOUNCE_CYCLES-1:
  - stable is loaded with `sync2` and the counter is cleared;
  - the matching rise or fall pulse is registered for the next cycle.

Consequences of the counter rule:
- Any bounce back to the stable value, even for one cycle, restarts the count.
- A glitch lasting fewer than DEBOUNCE_CYCLES synchronised cycles never reaches `o_Level`.

Outputs and toggle:
- `o_Level` is the stable register itself.
- `o_Rise`/`o_Fall` are registered and asserted in the same cycle that `o_Level` first shows its new value.
- `o_Toggle` flips in the cycle after the `o_Rise` pulse.
- `i_Toggle_Clr[n]` forces `o_Toggle[n]` to 0 and has priority over a coincident rise.
- `o_Out` is a pure combinational select. It adds no latency beyond the selected signal.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

## Timing

Reset (`i_Rst_L` = 0 at a rising edge):
- `sync1`, `sync2`, stable, counters, `o_Level`, `o_Rise`, `o_Fall`, `o_Toggle` and `o_Out` are all 0 after that edge.
- Reset mid-count discards all progress.
- After release, a switch held at 1 is accepted as a fresh rise: `o_Rise` pulses and the toggle flips.

Press latency:
- `i_Switch` changes before edge E and then stays stable.
- `sync2` shows the new value after edge E+1.
- `o_Level` and the edge pulse change after edge E+1+DEBOUNCE_CYCLES.
- This is a latency of DEBOUNCE_CYCLES+2 edges.

Pulse and toggle timing:
- `o_Rise`/`o_Fall` are high for exactly one cycle per accepted transition.
- Back-to-back opposite transitions are spaced by at least DEBOUNCE_CYCLES cycles.
- `o_Toggle` updates one edge after the `o_Rise` pulse.

Counter boundaries:
- The counter never wraps; the compare at DEBOUNCE_CYCLES-1 terminates the count.
- Inputs toggling every cycle never let the counter pass 1, so outputs remain at their reset value indefinitely.

## Test plan

All scenarios use NUM_CH=4 and DEBOUNCE_CYCLES=4.

1. Reset: hold `i_Rst_L`=0 for 3 cycles with `i_Switch`=4'hF. All outputs = 0. Release reset. `o_Level` = 4'hF exactly 6 edges after release, `o_Rise` = 4'hF for 1 cycle, then `o_Toggle` = 4'hF.
2. Bounce rejection: toggle `i_Switch[0]` every cycle for 100 cycles. `o_Level`, `o_Rise`, `o_Fall` and `o_Toggle` stay 0 throughout.
3. Clean press and release on ch1:
   - Hold 1 for 20 cycles: `o_Level[1]` rises at edge E+5 and `o_Rise[1]` pulses once.
   - Then release: `o_Fall[1]` pulses once and `o_Toggle[1]` remains 1.
4. Glitch mid-count: drive ch2 high for 3 cycles, low for 1, then high for 10. Acceptance occurs 6 edges after the final rise, not earlier.
5. Simultaneous events:
   - Press ch0 and ch3 in the same cycle: both `o_Rise` bits pulse in the same cycle.
   - Assert `i_Toggle_Clr[3]` in the cycle the toggle would flip: `o_Toggle[3]` = 0 and `o_Toggle[0]` = 1.
6. Mode check: with `TOGGLE_MODE`=1, two full press/release cycles on ch0 give `o_Out[0]` = 1 then 0. With `TOGGLE_MODE`=0, `o_Out` matches `o_Level` every cycle.

Source files
------------

// File: rtl/switch_debounce_multi_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_multi_if
// Bundles the per-channel switch inputs and conditioned outputs of
// switch_debounce_multi into one interface.
//   i_Switch     : raw, asynchronous push-button inputs (one bit per channel)
//   i_Toggle_Clr : per-channel synchronous clear of the toggle state
//   o_Level      : debounced, synchronised level
//   o_Rise       : one-cycle pulse on an accepted 0->1 transition
//   o_Fall       : one-cycle pulse on an accepted 1->0 transition
//   o_Toggle     : latch-on-press state, flips on every accepted rise
//   o_Out        : mode-selected output (level or toggle)
// master: the side that owns the switches (board top level or bench).
// slave : the conditioner itself.
// -----------------------------------------------------------------------------
interface switch_debounce_multi_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] i_Switch;
    logic [NUM_CH-1:0] i_Toggle_Clr;
    logic [NUM_CH-1:0] o_Level;
    logic [NUM_CH-1:0] o_Rise;
    logic [NUM_CH-1:0] o_Fall;
    logic [NUM_CH-1:0] o_Toggle;
    logic [NUM_CH-1:0] o_Out;

    modport master (
        output i_Switch,
        output i_Toggle_Clr,
        input  o_Level,
        input  o_Rise,
        input  o_Fall,
        input  o_Toggle,
        input  o_Out
    );

    modport slave (
        input  i_Switch,
        input  i_Toggle_Clr,
        output o_Level,
        output o_Rise,
        output o_Fall,
        output o_Toggle,
        output o_Out
    );
endinterface

// File: rtl/switch_debounce_multi.sv
// -----------------------------------------------------------------------------
// switch_debounce_multi
// Multi-channel push-button conditioner. Each channel is synchronised with two
// flops, then debounced by a stability counter: a new value must be seen for
// DEBOUNCE_CYCLES consecutive synchronised cycles before it is accepted.
// Per channel it provides a clean level, rise/fall pulses and a toggle state.
// Ports:
//   i_Clk   : system clock, rising edge
//   i_Rst_L : synchronous active-low reset
//   sw_if   : switch_debounce_multi_if slave modport (switch inputs, toggle
//             clears, level/rise/fall/toggle/out outputs)
// Parameters:
//   NUM_CH          : channel count (1..8)
//   DEBOUNCE_CYCLES : acceptance window in cycles (>= 2)
//   TOGGLE_MODE     : 0 -> o_Out = level, 1 -> o_Out = toggle
// -----------------------------------------------------------------------------
module switch_debounce_multi #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TOGGLE_MODE     = 0
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    switch_debounce_multi_if.slave sw_if
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_CH-1:0] sync1_q,  sync1_d;
    logic [NUM_CH-1:0] sync2_q,  sync2_d;
    logic [NUM_CH-1:0] stable_q, stable_d;
    logic [NUM_CH-1:0] rise_q,   rise_d;
    logic [NUM_CH-1:0] fall_q,   fall_d;
    logic [NUM_CH-1:0] toggle_q, toggle_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];

    // Next-state: synchroniser shift, per-channel debounce counter and toggle.
    always_comb begin
        sync1_d  = sw_if.i_Switch;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        toggle_d = toggle_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
        end

        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sync2_q[ch] == stable_q[ch]) begin
                // Any return to the accepted value restarts the window.
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_MAX) begin
                // Window complete: accept, and register the edge pulse so it
                // lines up with the cycle the new level first appears.
                stable_d[ch] = sync2_q[ch];
                cnt_d[ch]    = '0;
                rise_d[ch]   = sync2_q[ch];
                fall_d[ch]   = ~sync2_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end

            // Clear wins over a coincident rise pulse.
            if (sw_if.i_Toggle_Clr[ch]) begin
                toggle_d[ch] = 1'b0;
            end else if (rise_q[ch]) begin
                toggle_d[ch] = ~toggle_q[ch];
            end else begin
                toggle_d[ch] = toggle_q[ch];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            toggle_q <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign sw_if.o_Level  = stable_q;
    assign sw_if.o_Rise   = rise_q;
    assign sw_if.o_Fall   = fall_q;
    assign sw_if.o_Toggle = toggle_q;
    // Pure select, no extra latency on either path.
    assign sw_if.o_Out    = (TOGGLE_MODE != 0) ? toggle_q : stable_q;

endmodule

// File: tb/tb_switch_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce_multi
// Bench for switch_debounce_multi with NUM_CH=4, DEBOUNCE_CYCLES=4. Two
// instances share stimulus: one in level mode, one in toggle mode. A reference
// model tracks, per channel, the recent synchronised samples and accepts a new
// value once the last DEBOUNCE_CYCLES samples all disagree with the current
// level. Directed scenarios are followed by a random phase.
// -----------------------------------------------------------------------------
module tb_switch_debounce_multi;
    localparam int NCH = 4;
    localparam int DC  = 4;

    logic clk;
    logic rst_l;

    switch_debounce_multi_if #(.NUM_CH(NCH)) if0 ();
    switch_debounce_multi_if #(.NUM_CH(NCH)) if1 ();

    switch_debounce_multi #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DC), .TOGGLE_MODE(0)) u_dut0 (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .sw_if   (if0.slave)
    );

    switch_debounce_multi #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DC), .TOGGLE_MODE(1)) u_dut1 (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .sw_if   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [NCH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_rise = '0, m_fall = '0, m_tog = '0;
    bit hq [NCH][$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [NCH-1:0] sw, input logic [NCH-1:0] clr);
        logic [NCH-1:0] nl, nr, nf, nt;
        bit all_diff;
        if (!r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_tog = '0;
            for (int c = 0; c < NCH; c++) hq[c].delete();
        end else begin
            nl = m_lvl; nr = '0; nf = '0; nt = m_tog;
            for (int c = 0; c < NCH; c++) begin
                if (clr[c]) nt[c] = 1'b0;
                else if (m_rise[c]) nt[c] = ~m_tog[c];
                hq[c].push_back(m_s2[c]);
                if (hq[c].size() > DC) void'(hq[c].pop_front());
                all_diff = (hq[c].size() == DC);
                foreach (hq[c][k]) if (hq[c][k] == m_lvl[c]) all_diff = 1'b0;
                if (all_diff) begin
                    nl[c] = m_s2[c];
                    nr[c] = m_s2[c];
                    nf[c] = ~m_s2[c];
                    hq[c].delete();
                end
            end
            m_s2 = m_s1; m_s1 = sw;
            m_lvl = nl; m_rise = nr; m_fall = nf; m_tog = nt;
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, compare mid-cycle.
    task automatic tick(input logic r, input logic [NCH-1:0] sw, input logic [NCH-1:0] clr);
        rst_l = r;
        if0.i_Switch = sw; if0.i_Toggle_Clr = clr;
        if1.i_Switch = sw; if1.i_Toggle_Clr = clr;
        @(posedge clk);
        model_step(r, sw, clr);
        @(negedge clk);
        check_eq("level",  32'(if0.o_Level),  32'(m_lvl));
        check_eq("rise",   32'(if0.o_Rise),   32'(m_rise));
        check_eq("fall",   32'(if0.o_Fall),   32'(m_fall));
        check_eq("toggle", 32'(if0.o_Toggle), 32'(m_tog));
        check_eq("out_m0", 32'(if0.o_Out),    32'(m_lvl));
        check_eq("out_m1", 32'(if1.o_Out),    32'(m_tog));
        check_eq("lvl_m1", 32'(if1.o_Level),  32'(m_lvl));
    endtask

    initial begin
        int n, lat, cnt;
        logic [NCH-1:0] acc, sw, clr;
        logic r;

        rst_l = 1'b0;
        if0.i_Switch = '0; if0.i_Toggle_Clr = '0;
        if1.i_Switch = '0; if1.i_Toggle_Clr = '0;

        // 1: reset with switches held high, then release
        repeat (3) tick(1'b0, 4'hF, 4'h0);
        check_eq("rst_outs", 32'(if0.o_Level | if0.o_Rise | if0.o_Fall | if0.o_Toggle | if0.o_Out), 32'd0);
        n = 0;
        do begin
            tick(1'b1, 4'hF, 4'h0);
            n++;
        end while (if0.o_Level != 4'hF && n < 20);
        check_eq("rst_lat", 32'(n), 32'd6);
        check_eq("rst_rise", 32'(if0.o_Rise), 32'hF);
        tick(1'b1, 4'hF, 4'h0);
        check_eq("rst_rise_end", 32'(if0.o_Rise), 32'h0);
        check_eq("rst_tog", 32'(if0.o_Toggle), 32'hF);

        // 2: bounce rejection on ch0
        repeat (2) tick(1'b0, 4'h0, 4'h0);
        acc = '0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, {3'b000, 1'(i % 2)}, 4'h0);
            acc |= if0.o_Level | if0.o_Rise | if0.o_Fall | if0.o_Toggle;
        end
        check_eq("bounce", 32'(acc), 32'd0);

        // 3: clean press/release on ch1
        lat = 0; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 4'h2, 4'h0);
            if (if0.o_Level[1] && lat == 0) lat = i;
            cnt += int'(if0.o_Rise[1]);
        end
        check_eq("press_lat", 32'(lat), 32'd6);
        check_eq("press_rises", 32'(cnt), 32'd1);
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 4'h0, 4'h0);
            cnt += int'(if0.o_Fall[1]);
        end
        check_eq("rel_falls", 32'(cnt), 32'd1);
        check_eq("rel_tog", 32'(if0.o_Toggle[1]), 32'd1);

        // 4: glitch in the middle of the count on ch2
        repeat (2) tick(1'b0, 4'h0, 4'h0);
        repeat (3) tick(1'b1, 4'h4, 4'h0);
        tick(1'b1, 4'h0, 4'h0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 4'h4, 4'h0);
            if (if0.o_Level[2] && lat == 0) lat = i;
        end
        check_eq("glitch_lat", 32'(lat), 32'd6);

        // 5: simultaneous presses, toggle clear racing the flip on ch3
        repeat (2) tick(1'b0, 4'h0, 4'h0);
        n = 0;
        do begin
            tick(1'b1, 4'h9, 4'h0);
            n++;
        end while (if0.o_Rise == 4'h0 && n < 20);
        check_eq("simul_rise", 32'(if0.o_Rise), 32'h9);
        tick(1'b1, 4'h9, 4'h8);
        check_eq("clr_tog3", 32'(if0.o_Toggle[3]), 32'd0);
        check_eq("clr_tog0", 32'(if0.o_Toggle[0]), 32'd1);

        // 6: toggle-mode output over two press/release cycles on ch0
        repeat (2) tick(1'b0, 4'h0, 4'h0);
        repeat (12) tick(1'b1, 4'h1, 4'h0);
        check_eq("mode1_first", 32'(if1.o_Out[0]), 32'd1);
        repeat (12) tick(1'b1, 4'h0, 4'h0);
        repeat (12) tick(1'b1, 4'h1, 4'h0);
        check_eq("mode1_second", 32'(if1.o_Out[0]), 32'd0);
        repeat (12) tick(1'b1, 4'h0, 4'h0);

        // random phase: mostly-held switches with occasional bounces and clears
        sw = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) sw[c] = ~sw[c];
                clr[c] = ($urandom_range(0, 15) == 0);
            end
            r = ($urandom_range(0, 199) != 0);
            tick(r, sw, clr);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
